// File: rtl/count_sequencer.sv
// count_sequencer: command-driven load/count-pulse sequencer for an external counter.
// Define COUNT_SEQUENCER_BOUNCE_EN to add cmd_bounce (up-then-back second pass).
module count_sequencer #(
  parameter int STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_start,
  input  logic [7:0] cmd_steps,
  input  logic       cmd_up,
`ifdef COUNT_SEQUENCER_BOUNCE_EN
  input  logic       cmd_bounce,
`endif
  input  logic       hold,
  output logic       seq_load,
  output logic [7:0] seq_load_val,
  output logic       seq_count_en,
  output logic       seq_count_up,
  output logic       busy,
  output logic       done,
  output logic [7:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  state_t     r_state;
  logic [7:0] r_div;
  logic [7:0] r_steps_left;
  logic [7:0] r_start;
  logic       r_up;
  logic       r_count_en;

  logic       w_tick;
  logic       w_adv;
  logic       w_reflect;

  assign w_tick = (r_div == DIV_LAST);

  // The LOAD edge counts as the first divider step, so the first
  // pulse lands STEP_DIV cycles after the LOAD cycle.
  assign w_adv = (r_steps_left != 8'd0) &&
                 ((r_state == S_LOAD) ||
                  ((r_state == S_RUN) && !hold));

`ifdef COUNT_SEQUENCER_BOUNCE_EN
  logic [7:0] r_steps;
  logic       r_bounce;
  logic       r_pass;

  assign w_reflect = r_bounce && !r_pass;

  // Latch the pass length and bounce mode; mark the second pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps  <= 8'd0;
      r_bounce <= 1'b0;
      r_pass   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (cmd_valid) begin
        r_steps  <= cmd_steps;
        r_bounce <= cmd_bounce;
        r_pass   <= 1'b0;
      end
    end else if (r_state == S_RUN &&
                 r_steps_left == 8'd0 &&
                 w_reflect) begin
      r_pass <= 1'b1;
    end
  end
`else
  assign w_reflect = 1'b0;
`endif

  // Sequencer FSM; the pulse strobe is registered, so a pulse decided
  // at an edge is visible for the whole following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_div        <= 8'd0;
      r_steps_left <= 8'd0;
      r_start      <= 8'd0;
      r_up         <= 1'b0;
      r_count_en   <= 1'b0;
    end else begin
      r_count_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_state      <= S_LOAD;
            r_start      <= cmd_start;
            r_steps_left <= cmd_steps;
            r_up         <= cmd_up;
            r_div        <= 8'd0;
          end
        end
        S_LOAD: begin
          if (r_steps_left == 8'd0)
            r_state <= S_DONE;
          else
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_steps_left == 8'd0) begin
            if (w_reflect) begin
`ifdef COUNT_SEQUENCER_BOUNCE_EN
              r_steps_left <= r_steps;
`endif
              r_up  <= ~r_up;
              r_div <= 8'd0;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_adv) begin
        if (w_tick) begin
          r_div        <= 8'd0;
          r_count_en   <= 1'b1;
          r_steps_left <= r_steps_left - 8'd1;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign seq_load     = (r_state == S_LOAD);
  assign seq_load_val = r_start;
  assign seq_count_en = r_count_en;
  assign seq_count_up = busy & r_up;
  assign steps_left   = r_steps_left;

endmodule
